// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiply sequencing controller:
// FSM state encodings, default latencies and the modular address adder.
package vec_mul_pkg;

   localparam int DEF_UB_RD_LATENCY = 1;
   localparam int DEF_ARRAY_LATENCY = 2;
   localparam int DEF_RELOAD_CYCLES = 1;

   // Address arithmetic is done at this width and truncated by the caller,
   // which gives modulo-2^ADDRESSSIZE wrap for any ADDRESSSIZE up to 32.
   localparam int ADDR_CALC_W = 32;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_W = 3'd1;
   localparam logic [2:0] ST_RELOAD = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_DRAIN  = 3'd4;

   function automatic logic [ADDR_CALC_W-1:0] addr_add(
      input logic [ADDR_CALC_W-1:0] base,
      input logic [ADDR_CALC_W-1:0] offset
   );
      return base + offset;
   endfunction

endpackage

// File: rtl/vec_mul_valid_pipe.sv
// Fixed-depth shift register carrying {valid, address} alongside the
// UB-read + array latency, with a synchronous clear of the valid bits.
module vec_mul_valid_pipe #(
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_vld,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_vld,
   output logic [ADDR_W-1:0] out_addr,
   output logic              pending
);

   logic [DEPTH-1:0]  vld_p;
   logic [ADDR_W-1:0] addr_p [DEPTH];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= in_vld;
         for (int i = 1; i < DEPTH; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      addr_p[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
         addr_p[i] <= addr_p[i-1];
      end
   end

   assign out_vld  = vld_p[DEPTH-1];
   assign out_addr = addr_p[DEPTH-1];

   // An entry still in flight after this cycle: any valid short of the output stage.
   generate
      if (DEPTH > 1) begin : g_deep
         assign pending = |vld_p[DEPTH-2:0];
      end else begin : g_shallow
         assign pending = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// Job sequencer for the vector-multiply datapath: pops weights, strobes the
// reload, streams UB rows and generates results-SRAM write addresses per tile.
module vec_mul_seq_ctrl
   import vec_mul_pkg::*;
#(
   parameter int ADDRESSSIZE   = 10,
   parameter int CNT_W         = 8,
   parameter int UB_RD_LATENCY = DEF_UB_RD_LATENCY,
   parameter int ARRAY_LATENCY = DEF_ARRAY_LATENCY,
   parameter int RELOAD_CYCLES = DEF_RELOAD_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDRESSSIZE-1:0] ub_base,
   input  logic [ADDRESSSIZE-1:0] res_base,
   input  logic [CNT_W-1:0]       num_vecs,
   input  logic [CNT_W-1:0]       num_tiles,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   weight_reload,
   output logic                   ub_rd_en,
   output logic [ADDRESSSIZE-1:0] ub_addr,
   output logic                   res_we,
   output logic [ADDRESSSIZE-1:0] res_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   aborted
);

   localparam int PIPE_DEPTH = UB_RD_LATENCY + ARRAY_LATENCY;
   localparam int RCNT_W     = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RELOAD_CYCLES - 1);
   localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [2:0]             state;
   logic [CNT_W-1:0]       vec;
   logic [CNT_W-1:0]       tile;
   logic [RCNT_W-1:0]      rel_cnt;
   logic                   done_q;
   logic                   err_q;
   logic                   aborted_q;

   logic [CNT_W-1:0]       num_vecs_q;
   logic [CNT_W-1:0]       num_tiles_q;
   logic [ADDRESSSIZE-1:0] ub_base_q;
   logic [ADDRESSSIZE-1:0] tile_base;

   logic                   go_abort;
   logic                   job_ok;
   logic                   last_issue;
   logic [CNT_W:0]         tile_inc;
   logic                   more_tiles;
   logic                   drain_exit;
   logic                   tile_adv;
   logic                   pipe_vld;
   logic                   pipe_pending;
   logic [ADDRESSSIZE-1:0] pipe_addr;
   logic [ADDRESSSIZE-1:0] issue_ub_addr;
   logic [ADDRESSSIZE-1:0] issue_res_addr;

   assign go_abort   = abort && (state != ST_IDLE);
   assign job_ok     = (num_vecs != '0) && (num_tiles != '0);
   assign last_issue = (vec == num_vecs_q - CNT_ONE);
   assign tile_inc   = {1'b0, tile} + (CNT_W+1)'(1);
   assign more_tiles = tile_inc < {1'b0, num_tiles_q};
   assign drain_exit = (state == ST_DRAIN) && !pipe_pending && !go_abort;
   assign tile_adv   = drain_exit && more_tiles;

   // tile_base tracks res_base + tile*num_vecs by accumulation, so the
   // truncated-product address needs no multiplier.
   assign issue_ub_addr  = ADDRESSSIZE'(addr_add(ADDR_CALC_W'(ub_base_q), ADDR_CALC_W'(vec)));
   assign issue_res_addr = ADDRESSSIZE'(addr_add(ADDR_CALC_W'(tile_base), ADDR_CALC_W'(vec)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         vec       <= '0;
         tile      <= '0;
         rel_cnt   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
         if (go_abort) begin
            state     <= ST_IDLE;
            aborted_q <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     if (!job_ok) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                     end else begin
                        tile  <= '0;
                        state <= ST_LOAD_W;
                     end
                  end
               end
               ST_LOAD_W: begin
                  if (!fifo_empty) begin
                     rel_cnt <= '0;
                     state   <= ST_RELOAD;
                  end
               end
               ST_RELOAD: begin
                  if (rel_cnt == RCNT_LAST) begin
                     vec   <= '0;
                     state <= ST_STREAM;
                  end else begin
                     rel_cnt <= rel_cnt + RCNT_ONE;
                  end
               end
               ST_STREAM: begin
                  vec <= vec + CNT_ONE;
                  if (last_issue) begin
                     state <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  if (drain_exit) begin
                     if (more_tiles) begin
                        tile  <= tile_inc[CNT_W-1:0];
                        state <= ST_LOAD_W;
                     end else begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Job parameters are captured on the start cycle only; they are data, not control.
   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && start) begin
         ub_base_q   <= ub_base;
         num_vecs_q  <= num_vecs;
         num_tiles_q <= num_tiles;
         tile_base   <= res_base;
      end else if (tile_adv) begin
         tile_base <= ADDRESSSIZE'(addr_add(ADDR_CALC_W'(tile_base), ADDR_CALC_W'(num_vecs_q)));
      end
   end

   vec_mul_valid_pipe #(
      .DEPTH  (PIPE_DEPTH),
      .ADDR_W (ADDRESSSIZE)
   ) u_valid_pipe (
      .clk      (clk),
      .rst      (rst),
      .clr      (go_abort),
      .in_vld   (ub_rd_en),
      .in_addr  (issue_res_addr),
      .out_vld  (pipe_vld),
      .out_addr (pipe_addr),
      .pending  (pipe_pending)
   );

   assign busy             = (state != ST_IDLE);
   assign fifo_read_enable = (state == ST_LOAD_W) && !fifo_empty;
   assign weight_reload    = (state == ST_RELOAD);
   assign ub_rd_en         = (state == ST_STREAM);
   assign ub_addr          = ub_rd_en ? issue_ub_addr : '0;
   assign res_we           = pipe_vld;
   assign res_addr         = pipe_vld ? pipe_addr : '0;
   assign done             = done_q;
   assign err              = err_q;
   assign aborted          = aborted_q;

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// Directed bench for vec_mul_seq_ctrl: table of whole jobs plus hand-written
// stall, illegal-job, busy-start, abort and mid-job reset sequences.
module tb_vec_mul_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [9:0] ub_base = '0;
   logic [9:0] res_base = '0;
   logic [7:0] num_vecs = '0;
   logic [7:0] num_tiles = '0;
   logic       fifo_empty = 1'b0;
   logic       fifo_read_enable, weight_reload, ub_rd_en, res_we;
   logic [9:0] ub_addr, res_addr;
   logic       busy, done, err, aborted;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      int ub;
      int rb;
      int nv;
      int nt;
      bit abort_at_start;
      int lat;
      int pops;
      int issues;
      int last_res;
   } vec_t;

   vec_t tbl [6];

   vec_mul_seq_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .abort            (abort),
      .ub_base          (ub_base),
      .res_base         (res_base),
      .num_vecs         (num_vecs),
      .num_tiles        (num_tiles),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .weight_reload    (weight_reload),
      .ub_rd_en         (ub_rd_en),
      .ub_addr          (ub_addr),
      .res_we           (res_we),
      .res_addr         (res_addr),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .aborted          (aborted)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got time %0t expected completion", $time);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Job monitor: independent address/latency model fed by the expected job parameters.
   bit mon_en = 1'b0;
   int m_ub, m_rb, m_nv, m_pops, m_reloads, m_issues, m_writes, m_last_res;
   int issq [$];

   task automatic mon_clear(input int ub, input int rb, input int nv);
      m_ub = ub; m_rb = rb; m_nv = (nv == 0) ? 1 : nv;
      m_pops = 0; m_reloads = 0; m_issues = 0; m_writes = 0; m_last_res = -1;
      issq.delete();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (fifo_read_enable) m_pops++;
         if (weight_reload) begin
            m_reloads++;
            check("reload_with_results_in_flight", m_issues - m_writes, 0);
         end
         if (ub_rd_en) begin
            check("ub_addr", int'(ub_addr), (m_ub + (m_issues % m_nv)) % 1024);
            issq.push_back(cyc);
            m_issues++;
         end
         if (res_we) begin
            check("res_addr", int'(res_addr), (m_rb + m_writes) % 1024);
            check("res_we_has_issue", int'(issq.size() > 0), 1);
            if (issq.size() > 0) check("res_we_latency", cyc - issq.pop_front(), 3);
            m_writes++;
            m_last_res = int'(res_addr);
         end
      end
   end

   task automatic wait_done(input int c0, output int lat);
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            lat = cyc - c0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic drive_job(input int ub, input int rb, input int nv, input int nt);
      ub_base = 10'(ub);
      res_base = 10'(rb);
      num_vecs = 8'(nv);
      num_tiles = 8'(nt);
      start = 1'b1;
   endtask

   task automatic check_zero_outputs(input string name);
      logic [27:0] v;
      v = {fifo_read_enable, weight_reload, ub_rd_en, ub_addr, res_we, res_addr,
           busy, done, err, aborted};
      check(name, int'(v), 0);
   endtask

   task automatic run_job(input vec_t v, input string tag);
      int c0, lat;
      mon_clear(v.ub, v.rb, v.nv);
      mon_en = 1'b1;
      @(negedge clk);
      drive_job(v.ub, v.rb, v.nv, v.nt);
      abort = v.abort_at_start;
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check({tag, "_busy_after_start"}, int'(busy), 1);
      wait_done(c0, lat);
      check({tag, "_latency"}, lat, v.lat);
      check({tag, "_busy_at_done"}, int'(busy), 0);
      check({tag, "_err_at_done"}, int'(err), 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, int'(done), 0);
      check({tag, "_pops"}, m_pops, v.pops);
      check({tag, "_reloads"}, m_reloads, v.nt);
      check({tag, "_issues"}, m_issues, v.issues);
      check({tag, "_writes"}, m_writes, v.issues);
      check({tag, "_last_res"}, m_last_res, v.last_res);
      mon_en = 1'b0;
   endtask

   initial begin
      int c0, lat, cnt;

      //            ub    rb   nv nt ab  lat pops iss last
      tbl[0] = '{  10,  100,  4, 1, 0,  10, 1,   4, 103};
      tbl[1] = '{  20,    0,  2, 3, 0,  22, 3,   6,   5};
      tbl[2] = '{1022, 1023,  3, 1, 0,   9, 1,   3,   1};
      tbl[3] = '{   5,  200,  1, 2, 1,  13, 2,   2, 201};
      tbl[4] = '{   0, 1020,  5, 2, 0,  21, 2,  10,   5};
      tbl[5] = '{ 700,  640,  3, 4, 0,  33, 4,  12, 651};

      repeat (3) @(negedge clk);
      check_zero_outputs("reset_outputs_in_rst");
      rst = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset_outputs_after_rst");

      for (int i = 0; i < 6; i++) begin
         run_job(tbl[i], $sformatf("job%0d", i));
      end

      // Weight FIFO empty for the first five LOAD_W cycles.
      mon_clear(30, 300, 2);
      mon_en = 1'b1;
      @(negedge clk);
      drive_job(30, 300, 2, 1);
      fifo_empty = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_no_pop", int'(fifo_read_enable), 0);
         check("stall_no_ub_rd", int'(ub_rd_en), 0);
         check("stall_busy", int'(busy), 1);
         if (i < 4) @(negedge clk);
      end
      @(posedge clk);
      #1 fifo_empty = 1'b0;
      @(negedge clk);
      check("stall_pop_after_release", int'(fifo_read_enable), 1);
      wait_done(c0, lat);
      check("stall_latency", lat, 13);
      @(negedge clk);
      check("stall_pops", m_pops, 1);
      check("stall_last_res", m_last_res, 301);
      mon_en = 1'b0;

      // Illegal jobs: zero vectors, then zero tiles.
      mon_clear(0, 0, 1);
      mon_en = 1'b1;
      @(negedge clk);
      drive_job(40, 40, 0, 3);
      @(negedge clk);
      start = 1'b0;
      check("illegal_nv_err", int'(err), 1);
      check("illegal_nv_done", int'(done), 1);
      check("illegal_nv_busy", int'(busy), 0);
      @(negedge clk);
      check("illegal_nv_err_pulse", int'(err), 0);
      check("illegal_nv_busy_after", int'(busy), 0);
      drive_job(40, 40, 2, 0);
      @(negedge clk);
      start = 1'b0;
      check("illegal_nt_err", int'(err), 1);
      check("illegal_nt_done", int'(done), 1);
      repeat (4) @(negedge clk);
      check("illegal_pops", m_pops, 0);
      check("illegal_issues", m_issues, 0);
      mon_en = 1'b0;

      // A second start while busy must not disturb the running job.
      mon_clear(10, 100, 4);
      mon_en = 1'b1;
      @(negedge clk);
      drive_job(10, 100, 4, 1);
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      drive_job(500, 7, 7, 2);
      @(negedge clk);
      start = 1'b0;
      wait_done(c0, lat);
      check("busy_start_latency", lat, 10);
      @(negedge clk);
      check("busy_start_issues", m_issues, 4);
      check("busy_start_last_res", m_last_res, 103);
      mon_en = 1'b0;
      repeat (2) @(negedge clk);

      // Abort after two of four issues.
      mon_clear(10, 100, 4);
      mon_en = 1'b1;
      @(negedge clk);
      drive_job(10, 100, 4, 1);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_ack", int'(aborted), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_no_done", int'(done), 0);
      check("abort_no_ub_rd", int'(ub_rd_en), 0);
      @(negedge clk);
      check("abort_ack_pulse", int'(aborted), 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (res_we || done || aborted || busy) cnt++;
         @(negedge clk);
      end
      check("abort_quiet_after", cnt, 0);
      check("abort_issues", m_issues, 2);
      check("abort_writes", m_writes, 0);
      mon_en = 1'b0;
      run_job(tbl[0], "after_abort");

      // Reset in the middle of a job.
      mon_clear(10, 100, 4);
      mon_en = 1'b1;
      @(negedge clk);
      drive_job(10, 100, 4, 1);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("midjob_rst_outputs");
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (res_we || done || aborted || busy) cnt++;
      end
      check("midjob_rst_quiet_after", cnt, 0);
      check("midjob_rst_writes", m_writes, 0);
      mon_en = 1'b0;
      run_job(tbl[1], "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
